// File: rtl/time_surface_scanner_pkg.sv
// Shared types and constants for the DVS time-surface feature path.
package dvs_pkg;
    localparam int TS_W        = 16;
    localparam int GRID        = 16;
    localparam int REGION      = 4;
    localparam int ADDR_W      = 8;
    localparam int NUM_REGIONS = 16;

    typedef logic [TS_W-1:0] ts_t;
    typedef logic [4:0]      region_cnt_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_EMIT
    } scan_state_t;

    // Cell address {row[3:0], col[3:0]} -> region {row[3:2], col[3:2]}
    function automatic logic [3:0] region_of(input logic [ADDR_W-1:0] addr);
        return {addr[7:6], addr[3:2]};
    endfunction
endpackage

// File: rtl/time_surface_scanner_if.sv
// BRAM read port and feature stream of the time-surface scanner.
interface time_surface_scanner_if;
    import dvs_pkg::*;

    logic [ADDR_W-1:0] bram_addr;
    ts_t               bram_dout;
    logic              feat_valid;
    logic              feat_ready;
    logic [3:0]        feat_idx;
    region_cnt_t       feat_count;

    modport master (
        output bram_addr,
        input  bram_dout,
        output feat_valid,
        output feat_idx,
        output feat_count,
        input  feat_ready
    );

    modport slave (
        input  bram_addr,
        output bram_dout,
        input  feat_valid,
        input  feat_idx,
        input  feat_count,
        output feat_ready
    );
endinterface

// File: rtl/time_surface_scanner.sv
// Sweeps the 256-cell timestamp BRAM, counts recent cells per 4x4 region,
// then streams the 16 region counts over valid/ready.
module time_surface_scanner
    import dvs_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  ts_t                           now_ts,
    input  ts_t                           window,
    output logic                          busy,
    output logic                          done,
    time_surface_scanner_if.master        bus
);

    scan_state_t       r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_tag;
    logic              r_tag_v;
    ts_t               r_now, r_win;
    region_cnt_t       r_cnt [NUM_REGIONS];
    logic [3:0]        r_idx;
    logic              r_done;

    logic              w_start;
    logic              w_hs;
    ts_t               w_age;
    logic              w_recent;

    assign w_start  = (r_state == S_IDLE) && start;
    assign w_hs     = bus.feat_valid && bus.feat_ready;
    // Unsigned wrap subtraction handles timestamp rollover for free
    assign w_age    = r_now - bus.bram_dout;
    assign w_recent = r_tag_v && (w_age < r_win);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SCAN;
            S_SCAN:  if (r_addr == '1) w_next = S_DRAIN;
            S_DRAIN: w_next = S_EMIT;
            S_EMIT:  if (w_hs && (r_idx == 4'd15)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_tag   <= '0;
            r_tag_v <= 1'b0;
            r_now   <= '0;
            r_win   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGIONS; i++) r_cnt[i] <= '0;
        end else begin
            r_tag   <= r_addr;
            r_tag_v <= (r_state == S_SCAN);
            r_done  <= w_hs && (r_idx == 4'd15);

            if (w_start) begin
                r_now  <= now_ts;
                r_win  <= window;
                r_addr <= '0;
                r_idx  <= '0;
                for (int unsigned i = 0; i < NUM_REGIONS; i++) r_cnt[i] <= '0;
            end else begin
                if ((r_state == S_SCAN) && (r_addr != '1)) r_addr <= r_addr + 1'b1;
                if (w_recent) r_cnt[region_of(r_tag)] <= r_cnt[region_of(r_tag)] + 5'd1;
                if (w_hs) r_idx <= r_idx + 4'd1;
            end
        end
    end

    assign bus.bram_addr  = r_addr;
    assign bus.feat_valid = (r_state == S_EMIT);
    assign bus.feat_idx   = r_idx;
    assign bus.feat_count = (r_state == S_EMIT) ? r_cnt[r_idx] : '0;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;

endmodule

// File: tb/tb_time_surface_scanner.sv
// Directed table-driven bench for time_surface_scanner with a behavioural BRAM.
module tb_time_surface_scanner;
    import dvs_pkg::*;

    typedef struct {
        logic [15:0]      now;
        logic [15:0]      win;
        int unsigned      kind;
        logic [15:0]      fill;
        logic [15:0][4:0] exp;
        logic             bp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    ts_t  now_ts = '0;
    ts_t  window = '0;
    logic busy, done;

    time_surface_scanner_if bus();

    time_surface_scanner dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .now_ts (now_ts),
        .window (window),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) bus.bram_dout <= mem[bus.bram_addr];

    int tests = 0;
    int fails = 0;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0][4:0] all_cnt(input logic [4:0] v);
        logic [15:0][4:0] e;
        for (int i = 0; i < 16; i++) e[i] = v;
        return e;
    endfunction

    task automatic fill_mem(input int unsigned kind, input logic [15:0] v);
        case (kind)
            0: for (int i = 0; i < 256; i++) mem[i] = v;
            1: begin
                for (int i = 0; i < 256; i++) mem[i] = 16'd0;
                mem[8'h00] = 16'd4950; mem[8'h01] = 16'd4950;
                mem[8'h10] = 16'd4950; mem[8'h11] = 16'd4950;
                mem[8'hFF] = 16'd4950;
            end
            default: begin
                for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
                mem[8'h3C] = 16'hFFF0;
            end
        endcase
    endtask

    // Collects the 16 features of a scan already started; start was sampled at E0.
    task automatic collect(input vec_t v, input logic chk_lat, input string tag);
        int n;
        n = 1;
        while (!bus.feat_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " feat_valid_seen"}, bus.feat_valid, 1);
        if (chk_lat) check({tag, " latency"}, n - 1, 257);
        for (int k = 0; k < 16; k++) begin
            int w;
            w = 0;
            while (!bus.feat_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (v.bp && k == 5) begin
                bus.feat_ready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check({tag, " bp_valid"}, bus.feat_valid, 1);
                    check({tag, " bp_idx"}, bus.feat_idx, 5);
                    check({tag, " bp_count"}, bus.feat_count, v.exp[5]);
                    check({tag, " bp_done"}, done, 0);
                end
                bus.feat_ready = 1'b1;
            end
            check({tag, " valid"}, bus.feat_valid, 1);
            check({tag, " idx"}, bus.feat_idx, k);
            check({tag, " count"}, bus.feat_count, v.exp[k]);
            check({tag, " done_early"}, done, 0);
            @(negedge clk);
        end
        check({tag, " done_pulse"}, done, 1);
        check({tag, " busy_low"}, busy, 0);
        check({tag, " valid_low"}, bus.feat_valid, 0);
        @(negedge clk);
        check({tag, " done_once"}, done, 0);
    endtask

    task automatic run_vec(input vec_t v, input logic chk_lat, input string tag);
        fill_mem(v.kind, v.fill);
        now_ts = v.now;
        window = v.win;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        collect(v, chk_lat, tag);
    endtask

    initial begin
        vecs[0] = '{now: 16'd100,  win: 16'd200,   kind: 0, fill: 16'd0,    exp: all_cnt(5'd16), bp: 1'b0};
        vecs[1] = '{now: 16'd5000, win: 16'd100,   kind: 1, fill: 16'd0,    exp: all_cnt(5'd0),  bp: 1'b1};
        vecs[1].exp[0]  = 5'd4;
        vecs[1].exp[15] = 5'd1;
        vecs[2] = '{now: 16'h0010, win: 16'h0040,  kind: 2, fill: 16'd0,    exp: all_cnt(5'd0),  bp: 1'b0};
        vecs[2].exp[3]  = 5'd1;
        vecs[3] = '{now: 16'd1000, win: 16'd100,   kind: 0, fill: 16'd900,  exp: all_cnt(5'd0),  bp: 1'b0};
        vecs[4] = '{now: 16'd1000, win: 16'd101,   kind: 0, fill: 16'd900,  exp: all_cnt(5'd16), bp: 1'b0};
        vecs[5] = '{now: 16'd1000, win: 16'd0,     kind: 0, fill: 16'd900,  exp: all_cnt(5'd0),  bp: 1'b0};

        bus.feat_ready = 1'b1;
        fill_mem(0, 16'd0);
        repeat (2) @(negedge clk);
        check("rst addr", bus.bram_addr, 0);
        check("rst busy", busy, 0);
        check("rst valid", bus.feat_valid, 0);
        check("rst idx", bus.feat_idx, 0);
        check("rst count", bus.feat_count, 0);
        check("rst done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], (i == 0), $sformatf("v%0d", i));
            repeat (2) @(negedge clk);
        end

        // Second start mid-scan must not restart the sweep; then reset at addr 0x80.
        begin
            int n;
            fill_mem(0, 16'd0);
            now_ts = 16'd100;
            window = 16'd200;
            start  = 1'b1;
            @(negedge clk);
            start  = 1'b0;
            n = 0;
            while (bus.bram_addr != 8'h40 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("addr_reach_40", bus.bram_addr, 8'h40);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("restart_ignored addr", bus.bram_addr, 8'h41);
            check("restart_ignored busy", busy, 1);
            n = 0;
            while (bus.bram_addr != 8'h80 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("addr_reach_80", bus.bram_addr, 8'h80);
            rst_n = 1'b0;
            #1;
            check("midrst addr", bus.bram_addr, 0);
            check("midrst busy", busy, 0);
            check("midrst valid", bus.feat_valid, 0);
            check("midrst idx", bus.feat_idx, 0);
            check("midrst count", bus.feat_count, 0);
            check("midrst done", done, 0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            run_vec(vecs[0], 1'b1, "after_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/time_surface_scanner.md
# time_surface_scanner

Downstream feature-extraction stage for the 256×16 timestamp BRAM. On a start pulse it sweeps all 256 pixel-cell timestamps through the BRAM read-only port and counts "recent" cells, meaning cells whose age relative to a latched current timestamp is below a window. Counts are accumulated into a 4×4 grid of regions (4×4 cells each). It then streams the 16 region counts to the gesture classifier over a valid/ready handshake.

## Interface
- TS_W, 16, timestamp width
- GRID, 16, cells per side (address = {row[3:0], col[3:0]})
- REGION, 4, cells per region side
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  scan request, sampled only in IDLE
- now_ts  in  16  current timestamp, latched on accepted start
- window  in  16  recency window, latched on accepted start
- bram_addr  out  8  BRAM read-only port address
- bram_dout  in  16  BRAM read-only port data, 1-cycle registered read latency
- busy  out  1  high in every state except IDLE
- feat_valid  out  1  feature word valid
- feat_ready  in  1  consumer accepts feature
- feat_idx  out  4  region index {row[3:2], col[3:2]}
- feat_count  out  5  recent-cell count, 0..16
- done  out  1  one-cycle pulse after feature 15 handshake

## Operation
- States: IDLE, SCAN, DRAIN, EMIT.
- IDLE:
  - start=1 latches now_ts and window, clears all 16 counters and addr, then moves to SCAN.
  - start in any other state is ignored.
- SCAN:
  - Drives bram_addr = 0..255, incrementing each cycle.
  - A pipeline tag (address delayed 1 cycle, plus valid) accompanies each returned word.
  - After address 255 is issued, moves to DRAIN.
- DRAIN: consumes the final word (address 255), then moves to EMIT.
- Recency test:
  - age = now_ts − ts, modulo 2^16 (unsigned wrap subtraction).
  - Recent iff age < window. age == window is not recent. window = 0 gives all counts 0.
  - Never-written cells (ts = 0) need no special case.
- Accumulate: when a tagged word is recent, increment counter[{tag[7:6], tag[3:2]}]. Counters are 5 bits, maximum 16, so overflow is impossible.
- EMIT:
  - Presents feat_idx = 0..15 in order, with feat_count = counter[feat_idx].
  - Advances only on feat_valid & feat_ready.
  - On the handshake of idx 15: pulse done, go to IDLE.
- Concurrent writes on the BRAM read/write port during SCAN are allowed and are not blocked. A cell updated mid-scan contributes either its old or new value; both are acceptable.

## Timing
- Reset values:
  - state = IDLE
  - bram_addr = 0, busy = 0, feat_valid = 0, feat_idx = 0, feat_count = 0, done = 0
  - counters = 0, latched now_ts/window = 0
- Edge E0 samples start. bram_addr = k is driven during cycle Ek..Ek+1. Data for address k is accumulated at edge Ek+2.
- Address 255 is accumulated at E257. feat_valid first rises after E257.
- The 16 features take a minimum of 16 cycles at feat_ready = 1. done is high in the cycle following the last handshake. busy falls in that same cycle.
- With feat_valid high and feat_ready low, feat_idx and feat_count hold stable. feat_valid never drops before its handshake.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous) and the partial result is discarded.

## Structure
- Shared package dvs_pkg holds:
  - TS_W, GRID, REGION, ADDR_W = 8, NUM_REGIONS = 16
  - typedef ts_t (logic [15:0])
  - typedef region_cnt_t (logic [4:0])
  - scanner state enum scan_state_t
- No sub-module. The counter bank, age compare and FSM live in one module; the BRAM itself stays external.

## Test plan
- BRAM all zero, now_ts = 100, window = 200 -> all 16 feat_count = 16, feat_idx 0..15 in order, done pulses once.
- now_ts = 5000, window = 100:
  - Stimulus: ts = 4950 at 0x00, 0x01, 0x10, 0x11 and 0xFF; all other cells 0.
  - Response: count[0] = 4, count[15] = 1, rest 0.
- Wrap-around: now_ts = 0x0010, window = 0x0040, ts = 0xFFF0 at 0x3C (age 0x20) -> count[3] = 1, others 0.
- Boundary: now_ts = 1000, ts = 900 everywhere.
  - window = 100 -> all counts 0.
  - window = 101 -> all 16.
  - window = 0 -> all 0.
- Backpressure: hold feat_ready low for 10 cycles at idx 5 -> idx/count stable, no skipped or duplicated index, done only after idx 15 accepted.
- Second start during SCAN is ignored. Then assert rst_n low while bram_addr = 0x80 -> outputs at reset values. A fresh start then yields correct full results with first feat_valid 257 edges after start.
